// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: stage-register occupancy encoding,
// per-boundary payload widths and field offsets for packing/unpacking.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int REG_W  = 5;

  // IF/ID: {pc, instr}
  localparam int IFID_INSTR_LSB = 0;
  localparam int IFID_PC_LSB    = IFID_INSTR_LSB + XLEN;
  localparam int IFID_W         = IFID_PC_LSB + XLEN;

  // ID/EX: {ctrl, rd, imm, rs2_val, rs1_val}
  localparam int IDEX_RS1_LSB  = 0;
  localparam int IDEX_RS2_LSB  = IDEX_RS1_LSB + XLEN;
  localparam int IDEX_IMM_LSB  = IDEX_RS2_LSB + XLEN;
  localparam int IDEX_RD_LSB   = IDEX_IMM_LSB + XLEN;
  localparam int IDEX_CTRL_LSB = IDEX_RD_LSB + REG_W;
  localparam int IDEX_W        = IDEX_CTRL_LSB + CTRL_W;

  // EX/MEM: {ctrl, rd, store_data, result}
  localparam int EXMEM_RES_LSB  = 0;
  localparam int EXMEM_ST_LSB   = EXMEM_RES_LSB + XLEN;
  localparam int EXMEM_RD_LSB   = EXMEM_ST_LSB + XLEN;
  localparam int EXMEM_CTRL_LSB = EXMEM_RD_LSB + REG_W;
  localparam int EXMEM_W        = EXMEM_CTRL_LSB + CTRL_W;

  // MEM/WB: {ctrl, rd, wb_data}
  localparam int MEMWB_DATA_LSB = 0;
  localparam int MEMWB_RD_LSB   = MEMWB_DATA_LSB + XLEN;
  localparam int MEMWB_CTRL_LSB = MEMWB_RD_LSB + REG_W;
  localparam int MEMWB_W        = MEMWB_CTRL_LSB + CTRL_W;

  function automatic logic [XLEN-1:0] ifid_pc(input logic [IFID_W-1:0] p);
    return p[IFID_PC_LSB +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] ifid_instr(input logic [IFID_W-1:0] p);
    return p[IFID_INSTR_LSB +: XLEN];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Zero latency from inc to count update on the next edge; no backpressure.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= '0;
    end else if (inc && (out != {CNT_W{1'b1}})) begin
      out <= out + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, optional 2-entry skid and stall/bubble counters.
// Latency 1 cycle; SKID=1 gives a registered in_ready, SKID=0 passes out_ready through to in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_v;
  logic [DATA_W-1:0] main_d;
  logic              skid_v;
  logic [DATA_W-1:0] skid_d;
  occ_e              occ;
  logic              xfer_in;
  logic              xfer_out;

  assign xfer_in   = in_valid && in_ready && !flush;
  assign xfer_out  = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_comb begin
    occ = OCC_EMPTY;
    if (main_v) occ = skid_v ? OCC_SKID : OCC_FULL;
  end

  // Data is zeroed whenever an entry dies so bubbles read as all-zero payloads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v <= 1'b0;
      main_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      main_d <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (xfer_in) begin
            main_v <= 1'b1;
            main_d <= in_data;
          end
        end
        OCC_FULL: begin
          if (xfer_out) begin
            if (xfer_in) begin
              main_d <= in_data;
            end else begin
              main_v <= 1'b0;
              main_d <= '0;
            end
          end
        end
        OCC_SKID: begin
          if (xfer_out) main_d <= skid_d;
        end
        default: begin
          main_v <= 1'b0;
          main_d <= '0;
        end
      endcase
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          skid_v <= 1'b0;
          skid_d <= '0;
        end else if (flush) begin
          skid_v <= 1'b0;
          skid_d <= '0;
        end else if ((occ == OCC_FULL) && xfer_in && !xfer_out) begin
          skid_v <= 1'b1;
          skid_d <= in_data;
        end else if ((occ == OCC_SKID) && xfer_out) begin
          skid_v <= 1'b0;
          skid_d <= '0;
        end
      end
      assign in_ready = !skid_v;
    end else begin : g_noskid
      assign skid_v   = 1'b0;
      assign skid_d   = '0;
      assign in_ready = !main_v || out_ready;
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_v && !out_ready),
    .out   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!main_v && out_ready),
    .out   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance A is SKID=1/CNT_W=16, instance B is SKID=0/CNT_W=2,
// both checked against a queue-based occupancy model.
module tb_pipe_stage_reg;

  localparam int MAXA = 65535;
  localparam int MAXB = 3;

  logic clk = 1'b0;
  logic reset;

  logic        a_fl, a_iv, a_rdy, a_ov, a_ordy;
  logic [31:0] a_id, a_od;
  logic [15:0] a_stall, a_bub;
  logic        b_fl, b_iv, b_rdy, b_ov, b_ordy;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_stall, b_bub;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] a_seen[$];
  logic [31:0] b_seen[$];
  int sa, ba, sb, bb;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_fl), .in_valid(a_iv), .in_ready(a_rdy),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
    .stall_cnt(a_stall), .bubble_cnt(a_bub));

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(b_fl), .in_valid(b_iv), .in_ready(b_rdy),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
    .stall_cnt(b_stall), .bubble_cnt(b_bub));

  function automatic logic [31:0] head_a();
    if (qa.size() != 0) return qa[0];
    return 32'h0;
  endfunction

  function automatic logic [31:0] head_b();
    if (qb.size() != 0) return qb[0];
    return 32'h0;
  endfunction

  function automatic logic rdy_a();
    return qa.size() < 2;
  endfunction

  function automatic logic rdy_b();
    return (qb.size() == 0) || b_ordy;
  endfunction

  // Advance both reference queues by one clock using the inputs currently driven.
  task automatic model_step();
    logic pa, pb;
    if (!reset) begin
      qa.delete(); qb.delete();
      sa = 0; ba = 0; sb = 0; bb = 0;
    end else begin
      pa = a_iv && rdy_a() && !a_fl;
      pb = b_iv && rdy_b() && !b_fl;
      if (qa.size() != 0 && !a_ordy && sa < MAXA) sa++;
      if (qa.size() == 0 && a_ordy && ba < MAXA) ba++;
      if (qb.size() != 0 && !b_ordy && sb < MAXB) sb++;
      if (qb.size() == 0 && b_ordy && bb < MAXB) bb++;
      if (a_fl) qa.delete();
      else begin
        if (a_ordy && qa.size() != 0) void'(qa.pop_front());
        if (pa) qa.push_back(a_id);
      end
      if (b_fl) qb.delete();
      else begin
        if (b_ordy && qb.size() != 0) void'(qb.pop_front());
        if (pb) qb.push_back(b_id);
      end
    end
  endtask

  task automatic tick();
    model_step();
    if (reset && a_ov && a_ordy) a_seen.push_back(a_od);
    if (reset && b_ov && b_ordy) b_seen.push_back(b_od);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    ncmp++; if (a_ov !== 1'b0) begin nerr++; $display("FAIL rst_a_valid got=%b exp=0", a_ov); end
    ncmp++; if (a_od !== 32'h0) begin nerr++; $display("FAIL rst_a_data got=%h exp=0", a_od); end
    ncmp++; if (a_rdy !== 1'b1) begin nerr++; $display("FAIL rst_a_ready got=%b exp=1", a_rdy); end
    ncmp++; if (a_stall !== 16'h0 || a_bub !== 16'h0) begin nerr++; $display("FAIL rst_a_cnt got=%0d/%0d exp=0/0", a_stall, a_bub); end
    ncmp++; if (b_rdy !== 1'b1 || b_ov !== 1'b0) begin nerr++; $display("FAIL rst_b got rdy=%b ov=%b exp 1/0", b_rdy, b_ov); end
    tick();
    reset = 1'b1;
    #1;
    ncmp++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin nerr++; $display("FAIL rst_release_ready got=%b/%b exp=1/1", a_rdy, b_rdy); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h0;
    a_seen.delete();
    a_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_iv = (i < 3);
      a_id = vals[i];
      #1;
      ncmp++; if (a_ov !== (qa.size() != 0)) begin nerr++; $display("FAIL stream_valid i=%0d got=%b exp=%b", i, a_ov, qa.size() != 0); end
      ncmp++; if (a_od !== head_a()) begin nerr++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, a_od, head_a()); end
      if (i > 0) begin
        ncmp++; if (a_od !== vals[i-1]) begin nerr++; $display("FAIL stream_latency i=%0d got=%h exp=%h", i, a_od, vals[i-1]); end
      end
      tick();
    end
    a_iv = 1'b0;
    #1;
    ncmp++; if (a_seen.size() != 3) begin nerr++; $display("FAIL stream_count got=%0d exp=3", a_seen.size()); end
    ncmp++; if (a_stall !== 16'h0) begin nerr++; $display("FAIL stream_stall got=%0d exp=0", a_stall); end
    ncmp++; if (a_bub !== 16'(ba)) begin nerr++; $display("FAIL stream_bubble got=%0d exp=%0d", a_bub, ba); end
  endtask

  task automatic test_backpressure();
    logic [31:0] items [3];
    int idx;
    items[0] = 32'hA; items[1] = 32'hB; items[2] = 32'hC;
    idx = 0;
    a_seen.delete();
    a_ordy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      a_iv = (idx < 3);
      a_id = items[(idx < 3) ? idx : 2];
      #1;
      ncmp++; if (a_rdy !== rdy_a()) begin nerr++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, a_rdy, rdy_a()); end
      ncmp++; if (a_od !== head_a()) begin nerr++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, a_od, head_a()); end
      if (c == 2) begin
        ncmp++; if (a_rdy !== 1'b0) begin nerr++; $display("FAIL bp_ready_drop got=%b exp=0", a_rdy); end
      end
      if (a_iv && rdy_a()) idx++;
      tick();
    end
    a_ordy = 1'b1;
    for (int k = 0; k < 12 && a_seen.size() < 3; k++) begin
      a_iv = (idx < 3);
      a_id = items[(idx < 3) ? idx : 2];
      #1;
      ncmp++; if (a_od !== head_a()) begin nerr++; $display("FAIL bp_drain_data k=%0d got=%h exp=%h", k, a_od, head_a()); end
      if (a_iv && rdy_a()) idx++;
      tick();
    end
    a_iv = 1'b0;
    #1;
    ncmp++;
    if (a_seen.size() != 3) begin
      nerr++; $display("FAIL bp_count got=%0d exp=3", a_seen.size());
    end else if (a_seen[0] !== 32'hA || a_seen[1] !== 32'hB || a_seen[2] !== 32'hC) begin
      nerr++; $display("FAIL bp_order got=%h,%h,%h exp=a,b,c", a_seen[0], a_seen[1], a_seen[2]);
    end
    ncmp++; if (a_stall !== 16'd5) begin nerr++; $display("FAIL bp_stall got=%0d exp=5", a_stall); end
    ncmp++; if (a_bub !== 16'(ba)) begin nerr++; $display("FAIL bp_bubble got=%0d exp=%0d", a_bub, ba); end
  endtask

  task automatic test_flush();
    a_seen.delete();
    a_ordy = 1'b0;
    a_iv = 1'b1;
    a_id = 32'h1; tick();
    a_id = 32'h2; tick();
    a_id = 32'hD; a_fl = 1'b1;
    #1;
    ncmp++; if (a_rdy !== 1'b0 || a_ov !== 1'b1) begin nerr++; $display("FAIL flush_pre got rdy=%b ov=%b exp 0/1", a_rdy, a_ov); end
    tick();
    a_fl = 1'b0; a_iv = 1'b0;
    #1;
    ncmp++; if (a_ov !== 1'b0) begin nerr++; $display("FAIL flush_valid got=%b exp=0", a_ov); end
    ncmp++; if (a_od !== 32'h0) begin nerr++; $display("FAIL flush_data got=%h exp=0", a_od); end
    ncmp++; if (a_rdy !== 1'b1) begin nerr++; $display("FAIL flush_ready got=%b exp=1", a_rdy); end
    a_ordy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      ncmp++; if (a_ov !== 1'b0) begin nerr++; $display("FAIL flush_ghost c=%0d got=%b data=%h exp=0", c, a_ov, a_od); end
      tick();
    end
    ncmp++; if (a_seen.size() != 0) begin nerr++; $display("FAIL flush_seen got=%0d exp=0", a_seen.size()); end
    ncmp++; if (a_stall !== 16'(sa)) begin nerr++; $display("FAIL flush_stall got=%0d exp=%0d", a_stall, sa); end
  endtask

  task automatic test_skid0_toggle();
    logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] sent[$];
    int n;
    n = 0;
    b_seen.delete();
    b_iv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_ordy = pat[i];
      b_id = 32'h100 + n;
      #1;
      ncmp++; if (b_rdy !== rdy_b()) begin nerr++; $display("FAIL s0_ready i=%0d got=%b exp=%b", i, b_rdy, rdy_b()); end
      if (qb.size() != 0) begin
        ncmp++; if (b_rdy !== b_ordy) begin nerr++; $display("FAIL s0_mirror i=%0d got=%b exp=%b", i, b_rdy, b_ordy); end
      end
      ncmp++; if (b_od !== head_b()) begin nerr++; $display("FAIL s0_data i=%0d got=%h exp=%h", i, b_od, head_b()); end
      if (rdy_b()) begin sent.push_back(b_id); n++; end
      tick();
    end
    b_iv = 1'b0;
    b_ordy = 1'b1;
    tick(); tick();
    ncmp++;
    if (b_seen.size() != sent.size()) begin
      nerr++; $display("FAIL s0_count got=%0d exp=%0d", b_seen.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++)
        if (b_seen[i] !== sent[i]) begin nerr++; $display("FAIL s0_order i=%0d got=%h exp=%h", i, b_seen[i], sent[i]); break; end
    end
  endtask

  task automatic test_async_reset();
    a_ordy = 1'b0; a_iv = 1'b1; a_id = 32'h5A;
    tick();
    a_iv = 1'b0;
    tick(); tick();
    #1;
    ncmp++; if (a_ov !== 1'b1 || a_stall !== 16'(sa)) begin nerr++; $display("FAIL areset_pre got ov=%b stall=%0d exp 1/%0d", a_ov, a_stall, sa); end
    #2 reset = 1'b0;
    #1;
    ncmp++; if (a_ov !== 1'b0) begin nerr++; $display("FAIL areset_valid got=%b exp=0", a_ov); end
    ncmp++; if (a_od !== 32'h0) begin nerr++; $display("FAIL areset_data got=%h exp=0", a_od); end
    ncmp++; if (a_stall !== 16'h0 || a_bub !== 16'h0) begin nerr++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", a_stall, a_bub); end
    ncmp++; if (a_rdy !== 1'b1) begin nerr++; $display("FAIL areset_ready got=%b exp=1", a_rdy); end
    ncmp++; if (b_stall !== 2'h0 || b_bub !== 2'h0) begin nerr++; $display("FAIL areset_b_cnt got=%0d/%0d exp=0/0", b_stall, b_bub); end
    @(negedge clk);
    model_step();
    reset = 1'b1;
    a_seen.delete(); b_seen.delete();
  endtask

  task automatic test_saturation();
    b_ordy = 1'b0; b_iv = 1'b1; b_id = 32'h77;
    #1;
    ncmp++; if (b_stall !== 2'd0) begin nerr++; $display("FAIL sat_start got=%0d exp=0", b_stall); end
    tick();
    b_iv = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1;
    ncmp++; if (b_stall !== 2'd3) begin nerr++; $display("FAIL sat_reach got=%0d exp=3", b_stall); end
    for (int i = 0; i < 3; i++) tick();
    #1;
    ncmp++; if (b_stall !== 2'd3) begin nerr++; $display("FAIL sat_hold got=%0d exp=3", b_stall); end
    ncmp++; if (b_ov !== 1'b1 || b_od !== 32'h77) begin nerr++; $display("FAIL sat_data got=%b/%h exp=1/77", b_ov, b_od); end
    b_ordy = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic hold_a, hold_b;
    hold_a = 1'b0; hold_b = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_a) begin a_iv = ($urandom_range(0, 3) != 0); a_id = $urandom; end
      if (!hold_b) begin b_iv = ($urandom_range(0, 3) != 0); b_id = $urandom; end
      a_ordy = ($urandom_range(0, 99) < ((c < 200) ? 40 : 75));
      b_ordy = ($urandom_range(0, 99) < ((c < 200) ? 40 : 75));
      a_fl = ($urandom_range(0, 19) == 0);
      b_fl = ($urandom_range(0, 19) == 0);
      #1;
      ncmp++; if (a_ov !== (qa.size() != 0) || a_od !== head_a()) begin nerr++; $display("FAIL rnd_a_out c=%0d got=%b/%h exp=%b/%h", c, a_ov, a_od, qa.size() != 0, head_a()); end
      ncmp++; if (a_rdy !== rdy_a()) begin nerr++; $display("FAIL rnd_a_ready c=%0d got=%b exp=%b", c, a_rdy, rdy_a()); end
      ncmp++; if (a_stall !== 16'(sa) || a_bub !== 16'(ba)) begin nerr++; $display("FAIL rnd_a_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, a_stall, a_bub, sa, ba); end
      ncmp++; if (b_ov !== (qb.size() != 0) || b_od !== head_b()) begin nerr++; $display("FAIL rnd_b_out c=%0d got=%b/%h exp=%b/%h", c, b_ov, b_od, qb.size() != 0, head_b()); end
      ncmp++; if (b_rdy !== rdy_b()) begin nerr++; $display("FAIL rnd_b_ready c=%0d got=%b exp=%b", c, b_rdy, rdy_b()); end
      ncmp++; if (b_stall !== 2'(sb) || b_bub !== 2'(bb)) begin nerr++; $display("FAIL rnd_b_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, b_stall, b_bub, sb, bb); end
      hold_a = a_iv && !rdy_a();
      hold_b = b_iv && !rdy_b();
      tick();
    end
    a_iv = 1'b0; b_iv = 1'b0; a_fl = 1'b0; b_fl = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    a_fl = 1'b0; a_iv = 1'b0; a_id = '0; a_ordy = 1'b0;
    b_fl = 1'b0; b_iv = 1'b0; b_id = '0; b_ordy = 1'b0;
    sa = 0; ba = 0; sb = 0; bb = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0_toggle();
    test_async_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that carries a packed payload, such as instruction, PC, control and result fields, between two pipeline stages using a valid/ready handshake. It adds stall back-pressure, synchronous flush (bubble insertion), an optional skid buffer and saturating stall/bubble performance counters. It is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of fixed-field stage registers.

## Interface
- DATA_W, 32: packed payload width in bits (≥1).
- SKID, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry, `in_ready` combinational from `out_ready`.
- CNT_W, 16: width of each performance counter (≥2).
- clk  input  1  stage clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- flush  input  1  synchronous kill; discards every held and incoming entry this cycle.
- in_valid  input  1  upstream has a payload on `in_data`.
- in_ready  output  1  stage accepts `in_data` this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  `out_data` holds a live entry.
- out_ready  input  1  downstream consumes `out_data` this cycle.
- out_data  output  DATA_W  payload of the oldest held entry.
- stall_cnt  output  CNT_W  cycles with `out_valid && !out_ready`, saturating.
- bubble_cnt  output  CNT_W  cycles with `!out_valid && out_ready`, saturating.

## Operation
- Transfer in: `in_valid && in_ready && !flush`. Transfer out: `out_valid && out_ready`.
- Storage: main register (`main_v`, `main_d`), which drives `out_*`. When SKID=1 there is also a skid register (`skid_v`, `skid_d`).
- Occupancy states: EMPTY (main_v=0), FULL (main_v=1, skid_v=0), SKID (both valid; only reachable when SKID=1).
- EMPTY: on transfer in → FULL, main_d ← in_data.
- FULL: in+out → FULL with new data. Out only → EMPTY. In only → SKID=1: SKID, skid_d ← in_data; SKID=0: impossible, because in_ready=0.
- SKID: on out → FULL, main_d ← skid_d. No input is accepted, because in_ready=0.
- in_ready: SKID=1 → `!skid_v`. SKID=0 → `!main_v || out_ready`.
- flush has top priority: both valids ← 0 and both data ← 0 next cycle. A simultaneous input is dropped. A simultaneous output transfer still counts as consumed downstream.
- Invalid entries always read `out_data = 0`, so a bubble looks like a nop instruction with PC 0.
- Counters increment by 1 per qualifying cycle and hold at 2^CNT_W−1. flush does not clear them; only reset does.
- Payload contents are opaque. The block never inspects or modifies fields.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`. Throughput: 1 entry/cycle with out_ready held high.
- SKID=1: in_ready is a pure register output with no combinational path from out_ready. It deasserts the cycle after the skid register fills.
- SKID=0: combinational path out_ready → in_ready, valid for short stage boundaries only.
- Reset asserted, at any time including mid-transfer: main_v=skid_v=0, data=0, counters=0, out_valid=0, out_data=0. in_ready=1 while held in reset and after release.
- First input transfer is possible on the first posedge after reset deasserts.
- Upstream must hold in_data stable while in_valid && !in_ready. The block holds out_data stable while out_valid && !out_ready.

## Structure
- Shared package `pipe_pkg`: occupancy state encoding (EMPTY/FULL/SKID) and per-boundary payload width constants (e.g. EXMEM_W), plus field-offset localparams for packing and unpacking.
- One sub-module, `sat_counter` (CNT_W, inc, out), instantiated twice for the stall and bubble counters.
- Skid logic sits under a generate on SKID. Both variants share the main register.

## Test plan
- Streaming: reset, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 one cycle later each; stall_cnt=0.
- Back-pressure, SKID=1: out_ready=0 while sending 0xA,0xB,0xC → 0xA held at output, 0xB in skid, in_ready=0 from cycle 3, 0xC held upstream. Release out_ready → 0xA,0xB,0xC in order, none lost or duplicated; stall_cnt equals the stalled cycle count.
- Flush in SKID state, with in_valid=1 and 0xD carrying the same cycle → next cycle out_valid=0, out_data=0, in_ready=1; 0xD never appears.
- Async reset low mid-stall → out_valid, out_data and both counters read 0 before the next clock edge.
- Counter saturation with CNT_W=2: 5 stall cycles → stall_cnt=3 and it stays 3.
- SKID=0: out_ready toggles 1,0,1 with continuous input → in_ready mirrors out_ready in the same cycle once FULL; the output order is preserved.
